// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, command codes and
// default frame/data widths.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int SPI_FRAME_W = 10;
  localparam int SPI_DATA_W  = 8;

endpackage

// File: rtl/spi_tx_piso.sv
// Load-on-strobe parallel-to-serial shifter for MISO read data, MSB first.
// o_done stays set after the last bit until o_clr, so one load per frame.
module spi_tx_piso
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W);

  logic [DATA_W-1:0] r_sh;
  logic [CW-1:0]     r_cnt;
  logic              r_done;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_sh   <= i_data;
      r_cnt  <= CNT_LOAD;
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_sh  <= {r_sh[DATA_W-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_done <= 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_bit  = o_busy & r_sh[DATA_W-1];
  assign o_done = r_done;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front-end: MOSI frames to rx_data/rx_valid, RAM read data to MISO.
// Define SPI_FRAME_ERR_EN to add the frame_err abort-detect output.
//
// state     | meaning
// IDLE      | waiting for SS_n low
// CHK_CMD   | sample frame bit 9, pick write / read-address / read-data path
// WRITE     | receive write-address or write-data frame
// READ_ADD  | receive read-address frame (no read address held yet)
// READ_DATA | receive frame, then shift tx_data out on MISO
module spi_slave
  import spi_pkg::*;
#(
  parameter int FRAME_W = SPI_FRAME_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic               frame_err
`endif
);

  localparam int CW = $clog2(FRAME_W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);
  localparam logic [CW-1:0] CNT_DONE = CW'(FRAME_W + 1);

  spi_state_e         r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_held;

  logic       w_rx_state, w_abort, w_shift_en, w_frame_end, w_load, w_clr;
  logic       w_piso_bit, w_piso_busy, w_piso_done;
  logic [1:0] w_cmd;

  assign w_cmd      = r_shift[FRAME_W-1 -: 2];
  assign w_rx_state = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
  assign w_abort    = SS_n && (r_state != IDLE);
  assign w_clr      = w_abort || (r_state == IDLE);
  assign w_shift_en = !SS_n && ((r_state == CHK_CMD) || (w_rx_state && (r_cnt < CNT_FULL)));
  assign w_frame_end = !SS_n && w_rx_state && (r_cnt == CNT_FULL);
  assign w_load     = !SS_n && tx_valid && (r_state == READ_DATA) && (r_cnt == CNT_DONE)
                      && !w_piso_busy && !w_piso_done;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!SS_n) w_next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)       w_next = IDLE;
        else if (!MOSI) w_next = WRITE;
        else if (r_held) w_next = READ_DATA;
        else            w_next = READ_ADD;
      end
      default: if (SS_n) w_next = IDLE;
    endcase
  end

  // Frame is published one cycle after its last bit; r_cnt parks at CNT_DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_clr) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_W-2:0], MOSI};
        r_cnt   <= r_cnt + CW'(1);
      end else if (w_frame_end) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
        r_cnt      <= CNT_DONE;
        if (w_cmd == CMD_RD_ADDR)      r_held <= 1'b1;
        else if (w_cmd == CMD_RD_DATA) r_held <= 1'b0;
      end
    end
  end

  spi_tx_piso #(.DATA_W(DATA_W)) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_load (w_load),
    .i_data (tx_data),
    .o_bit  (w_piso_bit),
    .o_busy (w_piso_busy),
    .o_done (w_piso_done)
  );

  assign MISO     = w_piso_bit;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

`ifdef SPI_FRAME_ERR_EN
  logic r_frame_err;
  always_ff @(posedge clk) begin
    if (!rst_n) r_frame_err <= 1'b0;
    else        r_frame_err <= w_abort && (((r_cnt != '0) && (r_cnt < CNT_FULL)) || w_piso_busy);
  end
  assign frame_err = r_frame_err;
`endif

endmodule
